// File: rtl/polar_pkg.sv
// Shared constants and elaboration-time helpers for the polar encoder:
// code-length math, default frozen-set mask, info-position lookup and popcount.
package polar_pkg;

    localparam int MAX_N     = 64;
    localparam int N_DEFAULT = 8;
    localparam int K_DEFAULT = 4;
    localparam logic [N_DEFAULT-1:0] INFO_MASK_DEFAULT = 8'b1110_1000;

    function automatic int LOG2(input int v);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < v) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic int popcount(input logic [MAX_N-1:0] mask);
        int c;
        c = 32'sd0;
        for (int i = 32'sd0; i < MAX_N; i++) begin
            if (mask[i]) begin
                c = c + 32'sd1;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // Position of the j-th set bit of mask, counted from the LSB (0 if absent).
    function automatic int info_index(input logic [MAX_N-1:0] mask, input int j);
        int seen;
        int pos;
        seen = 32'sd0;
        pos  = 32'sd0;
        for (int i = 32'sd0; i < MAX_N; i++) begin
            if (mask[i]) begin
                if (seen == j) begin
                    pos = i;
                end else begin
                    pos = pos;
                end
                seen = seen + 32'sd1;
            end else begin
                seen = seen;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One registered XOR layer of the polar transform with its elastic valid/advance control.
module polar_butterfly_stage #(
    parameter int N    = 8,
    parameter int SPAN = 1
) (
    input  logic         clk,
    input  logic         rst_n_i,
    input  logic         valid_i,
    input  logic [N-1:0] data_i,
    input  logic         adv_next_i,
    output logic         valid_o,
    output logic [N-1:0] data_o
);

    logic [N-1:0] xor_s;
    logic         adv_s;
    logic         valid_d;
    logic         valid_q;
    logic [N-1:0] data_d;
    logic [N-1:0] data_q;

    // Upper half of each butterfly passes through; lower half folds in its partner.
    for (genvar i = 0; i < N; i++) begin : g_bfly
        if ((i & SPAN) == 0) begin : g_low
            assign xor_s[i] = data_i[i] ^ data_i[i + SPAN];
        end else begin : g_high
            assign xor_s[i] = data_i[i];
        end
    end

    assign adv_s = !valid_q || adv_next_i;

    // Next-state: take the upstream slot when this stage moves, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv_s) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = xor_s;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= {N{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/polar_encoder.sv
// Fully pipelined non-systematic Arikan polar encoder: info-bit insertion stage,
// log2(N) registered butterfly stages, elastic valid/ready flow, output frame counter.
module polar_encoder
    import polar_pkg::*;
#(
    parameter int            N         = N_DEFAULT,
    parameter int            K         = K_DEFAULT,
    parameter logic [N-1:0]  INFO_MASK = INFO_MASK_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_code,
    output logic [7:0]   out_frame_cnt
);

    localparam int LOGN = LOG2(N);
    localparam logic [MAX_N-1:0] MASK_W = MAX_N'(INFO_MASK);

    if ((N < 4) || (N > MAX_N) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("polar_encoder: N must be a power of two in 4..64");
    end
    if (popcount(MASK_W) != K) begin : g_bad_k
        $error("polar_encoder: K must equal popcount(INFO_MASK)");
    end

    logic [N-1:0]  u_s;
    logic          in_hs_s;
    logic          adv0_s;
    logic          v0_d;
    logic          v0_q;
    logic [N-1:0]  u_d;
    logic [N-1:0]  u_q;
    logic [LOGN:0] stg_valid_s;
    logic [N-1:0]  stg_data_s [0:LOGN];
    logic [LOGN:0] down_adv_s;
    logic          run_s;
    logic [7:0]    cnt_d;
    logic [7:0]    cnt_q;

    // Scatter info bits onto their mask positions; frozen positions are tied low.
    for (genvar j = 0; j < K; j++) begin : g_info
        localparam int POS = info_index(MASK_W, j);
        assign u_s[POS] = in_bits[j];
    end
    for (genvar i = 0; i < N; i++) begin : g_frozen
        if (!INFO_MASK[i]) begin : g_zero
            assign u_s[i] = 1'b0;
        end
    end

    // Downstream-advance for stage k depends only on registered valids and out_ready,
    // which keeps the ready chain acyclic.
    always_comb begin
        down_adv_s = {(LOGN + 1){1'b0}};
        run_s      = out_ready;
        for (int k = LOGN; k >= 32'sd0; k--) begin
            down_adv_s[k] = run_s;
            run_s         = run_s || !stg_valid_s[k];
        end
    end

    assign adv0_s   = !v0_q || down_adv_s[0];
    assign in_ready = rst_n && adv0_s;
    assign in_hs_s  = in_valid && in_ready;

    // Insert stage next-state.
    always_comb begin
        v0_d = v0_q;
        u_d  = u_q;
        if (adv0_s) begin
            v0_d = in_hs_s;
            if (in_hs_s) begin
                u_d = u_s;
            end else begin
                u_d = u_q;
            end
        end else begin
            v0_d = v0_q;
            u_d  = u_q;
        end
    end

    // Insert stage register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
            u_q  <= {N{1'b0}};
        end else begin
            v0_q <= v0_d;
            u_q  <= u_d;
        end
    end

    assign stg_valid_s[0] = v0_q;
    assign stg_data_s[0]  = u_q;

    for (genvar s = 1; s <= LOGN; s++) begin : g_stage
        polar_butterfly_stage #(
            .N    (N),
            .SPAN (1 << (s - 1))
        ) u_stage (
            .clk        (clk),
            .rst_n_i    (rst_n),
            .valid_i    (stg_valid_s[s - 1]),
            .data_i     (stg_data_s[s - 1]),
            .adv_next_i (down_adv_s[s]),
            .valid_o    (stg_valid_s[s]),
            .data_o     (stg_data_s[s])
        );
    end

    assign out_valid = stg_valid_s[LOGN];
    assign out_code  = stg_data_s[LOGN];

    // Output handshake counter next-state, wrapping modulo 256.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output handshake counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_frame_cnt = cnt_q;

endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder (N=8, K=4, mask 8'b1110_1000):
// directed vector table, streaming, backpressure, random stalls, mid-stream reset, counter wrap.
module tb_polar_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_bits;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic [7:0] out_frame_cnt;

    always #5 clk = ~clk;

    polar_encoder #(
        .N         (8),
        .K         (4),
        .INFO_MASK (8'b1110_1000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_bits       (in_bits),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_code      (out_code),
        .out_frame_cnt (out_frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: u has info bits at positions 3,5,6,7; x_j = XOR of u_i over all i containing j.
    function automatic logic [7:0] ref_code(input logic [3:0] b);
        logic [7:0] u;
        logic [7:0] x;
        u = {b[3], b[2], b[1], 1'b0, b[0], 3'b000};
        x = 8'h00;
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < 8; i++)
                if ((i & j) == j) x[j] = x[j] ^ u[i];
        return x;
    endfunction

    // Monitor: records expected codes at input handshakes and observed codes at output handshakes.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_cnt = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
            exp_cnt = 8'd0;
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_code);
                exp_cnt = exp_cnt + 8'd1;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_code(in_bits));
        end
    end

    int rd = 0;

    task automatic compare_stream(input string name);
        chk({name, " count"}, got_q.size(), exp_q.size());
        for (int k = rd; k < got_q.size(); k++)
            if (k < exp_q.size()) chk({name, " code"}, got_q[k], exp_q[k]);
        rd = got_q.size();
        chk({name, " frame_cnt"}, out_frame_cnt, exp_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] bits;
        logic [7:0] code;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int acc;
        int cyc;
        logic [7:0] held;

        tbl[0] = '{4'b0001, 8'h0F};
        tbl[1] = '{4'b0010, 8'h33};
        tbl[2] = '{4'b0100, 8'h55};
        tbl[3] = '{4'b1000, 8'hFF};
        tbl[4] = '{4'b1111, 8'h96};
        tbl[5] = '{4'b0000, 8'h00};

        rst_n = 1'b0; in_valid = 1'b0; in_bits = 4'h0; out_ready = 1'b1;
        step(); step();
        chk("reset out_valid", out_valid, 0);
        chk("reset out_code", out_code, 0);
        chk("reset frame_cnt", out_frame_cnt, 0);
        chk("reset in_ready", in_ready, 0);
        rst_n = 1'b1;
        step();

        // Single frames: result visible after the third edge following the handshake.
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1; in_bits = tbl[v].bits;
            #1;
            chk("single in_ready", in_ready, 1);
            step();
            in_valid = 1'b0; in_bits = 4'hA;
            step(); step();
            chk("single early valid", out_valid, 0);
            step();
            chk("single out_valid", out_valid, 1);
            chk("single out_code", out_code, tbl[v].code);
            step();
            chk("single drained", out_valid, 0);
        end
        chk("single frame_cnt", out_frame_cnt, 6);
        compare_stream("single");

        // Streaming 16 frames back to back from a fresh reset.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    in_valid = 1'b1; in_bits = 4'(i);
                    step();
                end
                in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (!out_valid && w < 10) begin step(); w++; end
                chk("stream first valid", (w < 10), 1);
                for (int c = 0; c < 16; c++) begin
                    chk("stream contiguous valid", out_valid, 1);
                    step();
                end
                chk("stream end", out_valid, 0);
            end
        join
        chk("stream frame_cnt", out_frame_cnt, 16);
        compare_stream("stream");

        // Backpressure: exactly four frames fit, head codeword holds steady.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_bits = 4'(acc + 1);
            #1;
            if (in_ready) acc++;
            step();
        end
        chk("bp accepted", acc, 4);
        chk("bp in_ready low", in_ready, 0);
        chk("bp out_valid", out_valid, 1);
        chk("bp head code", out_code, ref_code(4'd1));
        held = out_code;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp code held", out_code, held);
            chk("bp valid held", out_valid, 1);
        end
        in_bits = 4'd9; out_ready = 1'b1;
        #1;
        chk("bp simultaneous in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (8) step();
        compare_stream("backpressure");

        // Random valid/ready stalls over 1000 accepted frames.
        acc = 0; cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_bits   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) acc++;
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) step();
        chk("random accepted", acc, 1000);
        compare_stream("random");

        // Reset with three frames in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bits = 4'(i + 1);
            step();
        end
        in_valid = 1'b0;
        chk("midrst pre valid", out_valid, 0);
        rst_n = 1'b0;
        step();
        chk("midrst out_valid", out_valid, 0);
        chk("midrst frame_cnt", out_frame_cnt, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("midrst no stale", out_valid, 0);
        end
        compare_stream("midreset");

        // Counter wrap after 257 output handshakes.
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1; in_bits = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("wrap frame_cnt", out_frame_cnt, 1);
        compare_stream("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
